// File: rtl/btn_debounce_edge.sv
// Multi-channel button conditioner: synchroniser, debounce FSM, rise/fall pulses
// and an optional hold-to-auto-repeat press pulse per channel.
module btn_debounce_edge #(
   parameter int CHANNELS        = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_EN       = 1,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] btn_rise,
   output logic [CHANNELS-1:0] btn_fall,
   output logic [CHANNELS-1:0] btn_press
);

   localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RCW  = $clog2(RMAX + 1);

   typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} db_state_t;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync;
      logic                   s;
      db_state_t              state;
      logic [CW-1:0]          cnt;
      logic                   level_r;
      logic                   rise_r;
      logic                   fall_r;
      logic                   rise_acc;
      logic                   fall_acc;

      assign s        = sync[SYNC_STAGES-1];
      assign rise_acc = (state == CHK_HI) && s  && (cnt == CW'(DEBOUNCE_CYCLES));
      assign fall_acc = (state == CHK_LO) && !s && (cnt == CW'(DEBOUNCE_CYCLES));

      // Counter stops at DEBOUNCE_CYCLES on acceptance; any bounce zeroes it.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync    <= '0;
            state   <= STABLE_LO;
            cnt     <= '0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
         end else begin
            sync   <= {sync[SYNC_STAGES-2:0], btn_in[i]};
            rise_r <= rise_acc;
            fall_r <= fall_acc;
            case (state)
               STABLE_LO: begin
                  if (s) begin
                     state <= CHK_HI;
                     cnt   <= CW'(1);
                  end
               end
               CHK_HI: begin
                  if (!s) begin
                     state <= STABLE_LO;
                     cnt   <= '0;
                  end else if (rise_acc) begin
                     state   <= STABLE_HI;
                     level_r <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               STABLE_HI: begin
                  if (!s) begin
                     state <= CHK_LO;
                     cnt   <= CW'(1);
                  end
               end
               CHK_LO: begin
                  if (s) begin
                     state <= STABLE_HI;
                     cnt   <= '0;
                  end else if (fall_acc) begin
                     state   <= STABLE_LO;
                     level_r <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= STABLE_LO;
            endcase
         end
      end

      assign btn_level[i] = level_r;
      assign btn_rise[i]  = rise_r;
      assign btn_fall[i]  = fall_r;

      if (REPEAT_EN != 0) begin : g_rep
         logic [RCW-1:0] rcnt;
         logic           press_r;
         logic           held;

         assign held = (state == STABLE_HI) || (state == CHK_LO);

         // rcnt counts down to the next repeat; a fall acceptance suppresses it.
         always_ff @(posedge clk) begin
            if (rst) begin
               rcnt    <= '0;
               press_r <= 1'b0;
            end else if (rise_acc) begin
               press_r <= 1'b1;
               rcnt    <= RCW'(HOLD_CYCLES - 1);
            end else if (held && !fall_acc && (rcnt == '0)) begin
               press_r <= 1'b1;
               rcnt    <= RCW'(REPEAT_CYCLES - 1);
            end else begin
               press_r <= 1'b0;
               if (!held)
                  rcnt <= '0;
               else if (rcnt != '0)
                  rcnt <= rcnt - 1'b1;
            end
         end

         assign btn_press[i] = press_r;
      end else begin : g_norep
         assign btn_press[i] = rise_r;
      end
   end

endmodule
